muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter EARLY_OUT, default 1, meaning: 1 = divide-by-zero and signed-overflow results bypass iteration.
REQ-002 clk  input  1  rising-edge clock shared with the register file.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin an M-extension operation; sampled only in IDLE.
REQ-005 funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1_val  input  32  operand A, taken from register-file read port 1.
REQ-007 rs2_val  input  32  operand B, taken from register-file read port 2.
REQ-008 rd  input  5  destination register index.
REQ-009 busy  output  1  high from the cycle after acceptance through the result cycle; the core stalls the PC while it is high.
REQ-010 done  output  1  one-cycle pulse marking the result cycle.
REQ-011 wsig  output  1  register-file write enable; equals done AND (captured rd != 0).
REQ-012 wadd  output  5  captured rd, driven to the register-file write address.
REQ-013 wdata  output  32  result, driven to the register-file write data.

Function
REQ-014 The block SHALL use the FSM states IDLE, CALC and FIN.
REQ-015 In IDLE with start=1, the block SHALL capture funct3, rs1_val, rs2_val and rd at the clock edge and move to CALC; if EARLY_OUT=1 and a special case applies (REQ-020, REQ-021), it SHALL move directly to FIN instead.
REQ-016 CALC SHALL last exactly 32 cycles, processing one operand bit per cycle, and then move to FIN.
REQ-017 In FIN the block SHALL assert done and present a valid wdata for one cycle, then return to IDLE.
REQ-018 Latency: with start high in cycle 0, the block SHALL be busy in cycles 1-33, assert done in cycle 33, and accept a new start in cycle 34; the early-out path SHALL assert done in cycle 1.
REQ-019 Multiply SHALL be performed as a 32-iteration shift-add on magnitudes, producing a 64-bit product with sign correction.
REQ-019a MUL SHALL return product[31:0]; MULH/MULHSU/MULHU SHALL return product[63:32] with signed×signed, signed×unsigned and unsigned×unsigned semantics respectively.
REQ-020 Divide SHALL use restoring division on magnitudes; the quotient SHALL be negative iff the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-020a Divide by zero: DIV/DIVU SHALL return 0xFFFFFFFF, and REM/REMU SHALL return rs1_val.
REQ-021 Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV SHALL return 0x80000000 and REM SHALL return 0.
REQ-022 With EARLY_OUT=0, the special cases SHALL traverse CALC and still return exactly the REQ-020a/REQ-021 values.
REQ-023 start while busy=1 SHALL be ignored, and captured operands SHALL not change.
REQ-024 rd=0 SHALL complete normally with done=1 and wsig=0.
REQ-025 Outside FIN, wdata SHALL hold its last value and wsig SHALL be 0.

Reset
REQ-026 rst=1 SHALL force IDLE, busy=0, done=0, wsig=0, wadd=0 and wdata=0 asynchronously.
REQ-027 Reset mid-CALC SHALL abort the operation without ever producing a done pulse or write.
REQ-028 The first start after reset deasserts SHALL be accepted normally.

Structure
REQ-029 The funct3 encodings and the FSM state encodings SHALL live in a shared package, rv_pkg, reused by the decoder.
REQ-030 The block SHALL contain one sub-module, muldiv_signfix, which is combinational and handles operand magnitude conversion and result negation.
REQ-031 A single 6-bit iteration counter and a 65-bit shared accumulator/shift register SHALL serve both multiply and divide.

Verification
REQ-032 Scenario: MUL with 0x00000007 × 0xFFFFFFFD, rd=5 -> done in cycle 33, wdata=0xFFFFFFEB, wsig=1, wadd=5.
REQ-033 Scenario: MULHU with 0xFFFFFFFF × 0xFFFFFFFF -> wdata=0xFFFFFFFE; MULH with the same operands -> wdata=0x00000000.
REQ-034 Scenario: DIV with -7 / 2 -> wdata=0xFFFFFFFD; REM with -7 / 2 -> wdata=0xFFFFFFFF.
REQ-035 Scenario: DIVU with 0x1234 / 0 and EARLY_OUT=1 -> done in cycle 1, wdata=0xFFFFFFFF; REMU with the same operands -> wdata=0x1234.
REQ-036 Scenario: DIV with 0x80000000 / 0xFFFFFFFF, once with EARLY_OUT=0 and once with EARLY_OUT=1 -> wdata=0x80000000 in both cases.
REQ-037 Scenario: rst pulsed in cycle 10 of an operation -> busy falls immediately and no done occurs; a start issued while busy -> ignored; rd=0 -> wsig stays 0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32M definitions: funct3 encodings, muldiv FSM state encodings,
// datapath widths and the special-case (divide-by-zero / signed-overflow) helpers.
package rv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned ACC_W = 2 * XLEN + 1;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;
  localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

  // Divide ops whose result is fixed by the architecture rather than computed.
  function automatic logic is_special(input logic [2:0] f3,
                                      input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
    logic div0;
    logic ovf;
    div0 = (b == '0);
    ovf  = ((f3 == F3_DIV) || (f3 == F3_REM)) && (a == INT_MIN) && (b == ALL_ONES);
    return f3[2] && (div0 || ovf);
  endfunction

  // Fixed result of a special case; f3[1] distinguishes REM/REMU from DIV/DIVU.
  function automatic logic [XLEN-1:0] special_result(input logic [2:0] f3,
                                                     input logic [XLEN-1:0] a,
                                                     input logic [XLEN-1:0] b);
    if (b == '0) return f3[1] ? a : ALL_ONES;
    return f3[1] ? '0 : INT_MIN;
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign handling for the muldiv datapath.
// Ports:
//   i_funct3  RV32M op selecting signedness of each operand
//   i_a/i_b   raw operands
//   i_raw     unsigned 64-bit datapath result ({rem,quot} for divide, product for multiply)
//   o_a_mag   magnitude of operand A
//   o_b_mag   magnitude of operand B
//   o_result  final sign-corrected 32-bit result
module muldiv_signfix
  import rv_pkg::*;
(
  input  logic [2:0]        i_funct3,
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  input  logic [2*XLEN-1:0] i_raw,
  output logic [XLEN-1:0]   o_a_mag,
  output logic [XLEN-1:0]   o_b_mag,
  output logic [XLEN-1:0]   o_result
);

  logic                w_a_signed;
  logic                w_b_signed;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_quot;
  logic [XLEN-1:0]     w_rem;

  // MUL low half is sign-agnostic, so it shares the signed x signed path.
  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (i_funct3)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
      end
      F3_MULHSU: w_a_signed = 1'b1;
      default: ;
    endcase
  end

  assign w_a_neg = w_a_signed & i_a[XLEN-1];
  assign w_b_neg = w_b_signed & i_b[XLEN-1];

  assign o_a_mag = w_a_neg ? -i_a : i_a;
  assign o_b_mag = w_b_neg ? -i_b : i_b;

  // Quotient negative iff signs differ; remainder follows the dividend.
  assign w_prod = (w_a_neg ^ w_b_neg) ? -i_raw : i_raw;
  assign w_quot = (w_a_neg ^ w_b_neg) ? -i_raw[XLEN-1:0] : i_raw[XLEN-1:0];
  assign w_rem  = w_a_neg ? -i_raw[2*XLEN-1:XLEN] : i_raw[2*XLEN-1:XLEN];

  always_comb begin
    o_result = w_rem;
    case (i_funct3)
      F3_MUL:                        o_result = w_prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  o_result = w_prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               o_result = w_quot;
      default:                       o_result = w_rem;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and
// restoring divide sharing one 65-bit accumulator and one 6-bit counter.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           operation request, sampled only when idle
//   funct3          RV32M op select
//   rs1_val/rs2_val operands A/B
//   rd              destination register index
//   busy            high from the cycle after acceptance through the result cycle
//   done            one-cycle result pulse
//   wsig            register-file write enable (done and rd != 0)
//   wadd            captured rd
//   wdata           result, held between operations
module muldiv_unit
  import rv_pkg::*;
#(
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd,
  output logic            busy,
  output logic            done,
  output logic            wsig,
  output logic [4:0]      wadd,
  output logic [XLEN-1:0] wdata
);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [2:0]       r_f3;
  logic [XLEN-1:0]  r_a;
  logic [XLEN-1:0]  r_b;
  logic             r_special;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic             r_busy;
  logic             r_done;
  logic             r_wsig;
  logic [4:0]       r_wadd;
  logic [XLEN-1:0]  r_wdata;

  logic             w_idle;
  logic             w_accept;
  logic             w_in_special;
  logic [2:0]       w_f3_sel;
  logic [XLEN-1:0]  w_a_sel;
  logic [XLEN-1:0]  w_b_sel;
  logic [XLEN-1:0]  w_a_mag;
  logic [XLEN-1:0]  w_b_mag;
  logic [XLEN-1:0]  w_result;
  logic [XLEN:0]    w_mul_sum;
  logic [XLEN:0]    w_rem_sh;
  logic [XLEN-1:0]  w_diff;
  logic             w_ge;
  logic [ACC_W-1:0] w_acc_step;
  logic [ACC_W-1:0] w_acc_init;
  logic [XLEN-1:0]  w_fin_data;
  logic [4:0]       w_rd_sel;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_wsig_nxt;

  assign w_idle       = (r_state == ST_IDLE);
  assign w_accept     = w_idle && start;
  assign w_in_special = is_special(funct3, rs1_val, rs2_val);

  // While idle the sign fixer sees the live operands so the accumulator can be
  // seeded with magnitudes at the accept edge; afterwards it sees the captures.
  assign w_f3_sel = w_idle ? funct3  : r_f3;
  assign w_a_sel  = w_idle ? rs1_val : r_a;
  assign w_b_sel  = w_idle ? rs2_val : r_b;
  assign w_rd_sel = w_idle ? rd      : r_wadd;

  muldiv_signfix u_signfix (
    .i_funct3 (w_f3_sel),
    .i_a      (w_a_sel),
    .i_b      (w_b_sel),
    .i_raw    (w_acc_step[2*XLEN-1:0]),
    .o_a_mag  (w_a_mag),
    .o_b_mag  (w_b_mag),
    .o_result (w_result)
  );

  // One iteration: multiply adds A into the high half and shifts right;
  // divide shifts the remainder left and subtracts B when it fits.
  assign w_mul_sum = r_acc[ACC_W-1:XLEN] + {1'b0, (r_acc[0] ? w_a_mag : {XLEN{1'b0}})};
  assign w_rem_sh  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, w_b_mag});
  assign w_diff    = w_rem_sh[XLEN-1:0] - w_b_mag;

  always_comb begin
    w_acc_step = {1'b0, w_mul_sum, r_acc[XLEN-1:1]};
    if (r_f3[2]) begin
      w_acc_step = {1'b0, (w_ge ? w_diff : w_rem_sh[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};
    end
  end

  assign w_acc_init = {{(XLEN+1){1'b0}}, (funct3[2] ? w_a_mag : w_b_mag)};

  // Only a special case can jump from IDLE straight to FIN.
  assign w_fin_data = w_idle    ? special_result(funct3, rs1_val, rs2_val) :
                      r_special ? special_result(r_f3, r_a, r_b) : w_result;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next state and next registered outputs.
  always_comb begin
    w_next_state = r_state;
    w_busy_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
    w_wsig_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = (EARLY_OUT && w_in_special) ? ST_FIN : ST_CALC;
      end
      ST_CALC: begin
        if (r_cnt == CNT_W'(XLEN - 1)) w_next_state = ST_FIN;
      end
      ST_FIN:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
    w_busy_nxt = (w_next_state != ST_IDLE);
    w_done_nxt = (w_next_state == ST_FIN);
    w_wsig_nxt = w_done_nxt && (w_rd_sel != 5'd0);
  end

  // Operand capture, iteration counter and shared accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_f3      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_special <= 1'b0;
      r_cnt     <= '0;
      r_acc     <= '0;
    end else if (w_accept) begin
      r_f3      <= funct3;
      r_a       <= rs1_val;
      r_b       <= rs2_val;
      r_special <= w_in_special;
      r_cnt     <= '0;
      r_acc     <= w_acc_init;
    end else if (r_state == ST_CALC) begin
      r_cnt     <= r_cnt + CNT_W'(1);
      r_acc     <= w_acc_step;
    end
  end

  // Registered handshake and write-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wsig  <= 1'b0;
      r_wadd  <= '0;
      r_wdata <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_wsig <= w_wsig_nxt;
      if (w_accept)   r_wadd  <= rd;
      if (w_done_nxt) r_wdata <= w_fin_data;
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign wsig  = r_wsig;
  assign wadd  = r_wadd;
  assign wdata = r_wdata;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: drives one EARLY_OUT=1 and one EARLY_OUT=0 instance
// with identical stimulus and compares both against an arithmetic model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd;

  logic        busy1, done1, wsig1;
  logic [4:0]  wadd1;
  logic [31:0] wdata1;
  logic        busy0, done0, wsig0;
  logic [4:0]  wadd0;
  logic [31:0] wdata0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.EARLY_OUT(1'b1)) dut_eo1 (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .rs1_val(rs1_val),
    .rs2_val(rs2_val), .rd(rd), .busy(busy1), .done(done1), .wsig(wsig1),
    .wadd(wadd1), .wdata(wdata1)
  );

  muldiv_unit #(.EARLY_OUT(1'b0)) dut_eo0 (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .rs1_val(rs1_val),
    .rs2_val(rs2_val), .rd(rd), .busy(busy0), .done(done0), .wsig(wsig0),
    .wadd(wadd0), .wdata(wdata0)
  );

  typedef struct {
    int          lat1;
    int          lat0;
    logic [31:0] res1;
    logic [31:0] res0;
    logic        ws1;
    logic        ws0;
    logic [4:0]  wa1;
    logic [4:0]  wa0;
    bit          busy_ok;
    bit          pulse_ok;
    logic        post_busy;
    logic        post_ws;
    logic [31:0] post_wd1;
    logic [31:0] post_wd0;
  } obs_t;

  // RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_f(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = 0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit ref_special(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    if (!f3[2]) return 1'b0;
    if (b == 32'd0) return 1'b1;
    return (f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // Issue one op to both instances and record what they produce.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input bit intrude, output obs_t o);
    int cyc;
    bit got1, got0;
    o = '{lat1: -1, lat0: -1, res1: 32'd0, res0: 32'd0, ws1: 1'b0, ws0: 1'b0,
          wa1: 5'd0, wa0: 5'd0, busy_ok: 1'b1, pulse_ok: 1'b1, post_busy: 1'b0,
          post_ws: 1'b0, post_wd1: 32'd0, post_wd0: 32'd0};
    @(negedge clk);
    start = 1'b1; funct3 = f3; rs1_val = a; rs2_val = b; rd = r;
    cyc = 0; got1 = 1'b0; got0 = 1'b0;
    while (!(got1 && got0) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (intrude && cyc == 5) begin
        start = 1'b1; funct3 = 3'($urandom); rs1_val = $urandom; rs2_val = $urandom;
        rd = 5'($urandom);
      end
      if (!got1 && busy1 !== 1'b1) o.busy_ok = 1'b0;
      if (!got0 && busy0 !== 1'b1) o.busy_ok = 1'b0;
      if (got1 && done1 !== 1'b0) o.pulse_ok = 1'b0;
      if (!got1 && done1 === 1'b1) begin
        got1 = 1'b1; o.lat1 = cyc; o.res1 = wdata1; o.ws1 = wsig1; o.wa1 = wadd1;
      end
      if (!got0 && done0 === 1'b1) begin
        got0 = 1'b1; o.lat0 = cyc; o.res0 = wdata0; o.ws0 = wsig0; o.wa0 = wadd0;
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    o.post_busy = busy1 | busy0;
    o.post_ws   = wsig1 | wsig0 | done1 | done0;
    o.post_wd1  = wdata1;
    o.post_wd0  = wdata0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; funct3 = 3'd0; rs1_val = 32'd0; rs2_val = 32'd0; rd = 5'd0;
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy1, done1, wsig1, wadd1, wdata1} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_eo1: got busy=%b done=%b wsig=%b wadd=%0d wdata=%h, want all 0",
               busy1, done1, wsig1, wadd1, wdata1);
    end
    n_checks++;
    if ({busy0, done0, wsig0, wadd0, wdata0} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_eo0: got busy=%b done=%b wsig=%b wadd=%0d wdata=%h, want all 0",
               busy0, done0, wsig0, wadd0, wdata0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]  f3 [12] = '{3'd0, 3'd3, 3'd1, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd2, 3'd4, 3'd1};
    logic [31:0] va [12] = '{32'h7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                             32'h1234, 32'h1234, 32'h80000000, 32'h80000000, 32'hFFFFFFFF,
                             32'h80000000, 32'h80000000};
    logic [31:0] vb [12] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h2, 32'h2, 32'h0,
                             32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h80000000};
    logic [31:0] ve [12] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFD, 32'hFFFFFFFF,
                             32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'h0, 32'hFFFFFFFF,
                             32'hFFFFFFFF, 32'h40000000};
    int          vl [12] = '{33, 33, 33, 33, 33, 1, 1, 1, 1, 33, 1, 33};
    logic [4:0]  vr [12] = '{5'd5, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd0, 5'd31};
    obs_t o;
    for (int i = 0; i < 12; i++) begin
      run_op(f3[i], va[i], vb[i], vr[i], 1'b0, o);
      n_checks++;
      if (o.res1 !== ve[i] || o.res0 !== ve[i]) begin
        n_fail++;
        $display("FAIL dir%0d_wdata: got eo1=%h eo0=%h, want %h", i, o.res1, o.res0, ve[i]);
      end
      n_checks++;
      if (o.lat1 != vl[i] || o.lat0 != 33) begin
        n_fail++;
        $display("FAIL dir%0d_latency: got eo1=%0d eo0=%0d, want %0d/33", i, o.lat1, o.lat0, vl[i]);
      end
      n_checks++;
      if (o.ws1 !== (vr[i] != 5'd0) || o.ws0 !== (vr[i] != 5'd0) || o.wa1 !== vr[i] || o.wa0 !== vr[i]) begin
        n_fail++;
        $display("FAIL dir%0d_wport: got wsig=%b/%b wadd=%0d/%0d, want wsig=%b wadd=%0d",
                 i, o.ws1, o.ws0, o.wa1, o.wa0, vr[i] != 5'd0, vr[i]);
      end
      n_checks++;
      if (!o.busy_ok || !o.pulse_ok || o.post_busy !== 1'b0 || o.post_ws !== 1'b0 ||
          o.post_wd1 !== ve[i] || o.post_wd0 !== ve[i]) begin
        n_fail++;
        $display("FAIL dir%0d_handshake: busy_ok=%b pulse_ok=%b post_busy=%b post_ws=%b post_wdata=%h/%h, want 1 1 0 0 %h",
                 i, o.busy_ok, o.pulse_ok, o.post_busy, o.post_ws, o.post_wd1, o.post_wd0, ve[i]);
      end
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic [2:0]  f3;
    logic [31:0] a, b, e;
    logic [4:0]  r;
    int          el;
    for (int i = 0; i < 64; i++) begin
      f3 = 3'($urandom);
      a  = $urandom;
      b  = $urandom;
      r  = 5'($urandom);
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 40)) - 32'd20; b = 32'($urandom_range(0, 40)) - 32'd20; end
        3: begin a = 32'h8000_0000 ^ 32'($urandom_range(0, 1)); b = 32'($urandom_range(1, 3)); end
        default: ;
      endcase
      e  = ref_f(f3, a, b);
      el = ref_special(f3, a, b) ? 1 : 33;
      run_op(f3, a, b, r, 1'b0, o);
      n_checks++;
      if (o.res1 !== e || o.res0 !== e) begin
        n_fail++;
        $display("FAIL rnd%0d_wdata f3=%0d a=%h b=%h: got eo1=%h eo0=%h, want %h",
                 i, f3, a, b, o.res1, o.res0, e);
      end
      n_checks++;
      if (o.lat1 != el || o.lat0 != 33) begin
        n_fail++;
        $display("FAIL rnd%0d_latency: got eo1=%0d eo0=%0d, want %0d/33", i, o.lat1, o.lat0, el);
      end
      n_checks++;
      if (o.ws1 !== (r != 5'd0) || o.ws0 !== (r != 5'd0) || o.wa1 !== r || o.wa0 !== r ||
          !o.busy_ok || !o.pulse_ok || o.post_busy !== 1'b0 || o.post_ws !== 1'b0 ||
          o.post_wd1 !== e || o.post_wd0 !== e) begin
        n_fail++;
        $display("FAIL rnd%0d_port: wsig=%b/%b wadd=%0d/%0d busy_ok=%b pulse_ok=%b post_busy=%b post_ws=%b, want wsig=%b wadd=%0d 1 1 0 0",
                 i, o.ws1, o.ws0, o.wa1, o.wa0, o.busy_ok, o.pulse_ok, o.post_busy, o.post_ws,
                 r != 5'd0, r);
      end
    end
  endtask

  task automatic test_busy_ignore();
    obs_t o;
    logic [31:0] a, b, e;
    a = $urandom;
    b = $urandom | 32'd1;
    e = ref_f(3'd1, a, b);
    run_op(3'd1, a, b, 5'd12, 1'b1, o);
    n_checks++;
    if (o.res1 !== e || o.res0 !== e || o.wa1 !== 5'd12 || o.wa0 !== 5'd12) begin
      n_fail++;
      $display("FAIL busy_ignore: got wdata=%h/%h wadd=%0d/%0d, want %h wadd=12",
               o.res1, o.res0, o.wa1, o.wa0, e);
    end
    n_checks++;
    if (o.lat1 != 33 || o.lat0 != 33 || o.post_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ignore_timing: got lat=%0d/%0d post_busy=%b, want 33/33 0",
               o.lat1, o.lat0, o.post_busy);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    bit   saw;
    logic [31:0] e;
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; rs1_val = 32'd123456; rs2_val = 32'd789; rd = 5'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy1, busy0, done1, done0, wsig1, wsig0} !== 6'd0 || wadd1 !== 5'd0 || wdata1 !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got busy=%b/%b done=%b/%b wsig=%b/%b wadd=%0d wdata=%h, want all 0",
               busy1, busy0, done1, done0, wsig1, wsig0, wadd1, wdata1);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done1 || done0 || wsig1 || wsig0 || busy1 || busy0) saw = 1'b1;
    end
    n_checks++;
    if (saw) begin
      n_fail++;
      $display("FAIL reset_mid_abort: got activity after reset=1, want 0");
    end
    e = ref_f(3'd5, 32'd1000, 32'd7);
    run_op(3'd5, 32'd1000, 32'd7, 5'd17, 1'b0, o);
    n_checks++;
    if (o.res1 !== e || o.res0 !== e || o.lat1 != 33 || o.lat0 != 33 || o.ws1 !== 1'b1) begin
      n_fail++;
      $display("FAIL first_after_reset: got wdata=%h/%h lat=%0d/%0d wsig=%b, want %h 33/33 1",
               o.res1, o.res0, o.lat1, o.lat0, o.ws1, e);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
